// File: rtl/axi4lite_master_arbiter_if.sv
// Requester-side (s_*) and transactor-side (m_*) AXI4-Lite buses of the master arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface axi4lite_master_arbiter_if #(
    parameter int NUM_M     = 4,
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
);
    localparam int SW = dataWidth / 8;

    logic [NUM_M-1:0]           s_awvalid, s_awready;
    logic [NUM_M*addrWidth-1:0] s_awaddr;
    logic [NUM_M*3-1:0]         s_awprot;
    logic [NUM_M-1:0]           s_wvalid, s_wready;
    logic [NUM_M*dataWidth-1:0] s_wdata;
    logic [NUM_M*SW-1:0]        s_wstrb;
    logic [NUM_M-1:0]           s_bvalid, s_bready;
    logic [1:0]                 s_bresp;
    logic [NUM_M-1:0]           s_arvalid, s_arready;
    logic [NUM_M*addrWidth-1:0] s_araddr;
    logic [NUM_M*3-1:0]         s_arprot;
    logic [NUM_M-1:0]           s_rvalid, s_rready;
    logic [dataWidth-1:0]       s_rdata;
    logic [1:0]                 s_rresp;

    logic                       m_awvalid, m_awready;
    logic [addrWidth-1:0]       m_awaddr;
    logic [2:0]                 m_awprot;
    logic                       m_wvalid, m_wready;
    logic [dataWidth-1:0]       m_wdata;
    logic [SW-1:0]              m_wstrb;
    logic                       m_bvalid, m_bready;
    logic [1:0]                 m_bresp;
    logic                       m_arvalid, m_arready;
    logic [addrWidth-1:0]       m_araddr;
    logic [2:0]                 m_arprot;
    logic                       m_rvalid, m_rready;
    logic [dataWidth-1:0]       m_rdata;
    logic [1:0]                 m_rresp;

    modport master (
        input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_arprot, s_rready,
               m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
               m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_arprot, m_rready
    );

    modport slave (
        output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_arprot, s_rready,
               m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
               m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_arprot, m_rready
    );
endinterface

// File: rtl/axi4lite_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_M requesters,
// with a single outstanding transaction and the granted requester muxed combinationally.
module axi4lite_master_arbiter #(
    parameter int NUM_M     = 4,
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    axi4lite_master_arbiter_if.master  bus,
    output logic [$clog2(NUM_M)-1:0]   o_grant_id,
    output logic                       o_busy
);
    localparam int GW = $clog2(NUM_M);
    localparam int SW = dataWidth / 8;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_t;

    state_t           r_state, w_next;
    logic [GW-1:0]    r_grant, r_rr_ptr, w_winner;
    logic             w_found, w_done;
    logic [NUM_M-1:0] w_req;

    assign w_req = bus.s_awvalid | bus.s_arvalid;

    // First requester found searching upward from the one after the last served master.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_M;
            if (!w_found && w_req[idx]) begin
                w_found  = 1'b1;
                w_winner = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= GW'(NUM_M - 1);
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found)
                r_grant <= w_winner;
            if (w_done)
                r_rr_ptr <= r_grant;
        end
    end

    // Payloads follow the grant at all times; only the handshakes are phase-gated.
    assign bus.m_awaddr = bus.s_awaddr[int'(r_grant)*addrWidth +: addrWidth];
    assign bus.m_awprot = bus.s_awprot[int'(r_grant)*3 +: 3];
    assign bus.m_wdata  = bus.s_wdata[int'(r_grant)*dataWidth +: dataWidth];
    assign bus.m_wstrb  = bus.s_wstrb[int'(r_grant)*SW +: SW];
    assign bus.m_araddr = bus.s_araddr[int'(r_grant)*addrWidth +: addrWidth];
    assign bus.m_arprot = bus.s_arprot[int'(r_grant)*3 +: 3];
    assign bus.s_bresp  = bus.m_bresp;
    assign bus.s_rdata  = bus.m_rdata;
    assign bus.s_rresp  = bus.m_rresp;

    always_comb begin
        w_next        = r_state;
        w_done        = 1'b0;
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        bus.s_awready = '0;
        bus.s_wready  = '0;
        bus.s_bvalid  = '0;
        bus.s_arready = '0;
        bus.s_rvalid  = '0;
        case (r_state)
            IDLE: begin
                if (w_found)
                    w_next = bus.s_awvalid[w_winner] ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                bus.m_awvalid          = bus.s_awvalid[r_grant];
                bus.s_awready[r_grant] = bus.m_awready;
                if (bus.s_awvalid[r_grant] && bus.m_awready)
                    w_next = WR_DATA;
            end
            WR_DATA: begin
                bus.m_wvalid          = bus.s_wvalid[r_grant];
                bus.s_wready[r_grant] = bus.m_wready;
                if (bus.s_wvalid[r_grant] && bus.m_wready)
                    w_next = WR_RESP;
            end
            WR_RESP: begin
                bus.m_bready          = bus.s_bready[r_grant];
                bus.s_bvalid[r_grant] = bus.m_bvalid;
                if (bus.m_bvalid && bus.s_bready[r_grant]) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            RD_ADDR: begin
                bus.m_arvalid          = bus.s_arvalid[r_grant];
                bus.s_arready[r_grant] = bus.m_arready;
                if (bus.s_arvalid[r_grant] && bus.m_arready)
                    w_next = RD_DATA;
            end
            RD_DATA: begin
                bus.m_rready          = bus.s_rready[r_grant];
                bus.s_rvalid[r_grant] = bus.m_rvalid;
                if (bus.m_rvalid && bus.s_rready[r_grant]) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_grant_id = r_grant;
    assign o_busy     = (r_state != IDLE);
endmodule
